// File: rtl/exp5_sonar.sv
// rtl/exp5_sonar.sv - sweeping HC-SR04 sonar: servo stepping, echo ranging, "AAA,DDD#" UART report
module exp5_sonar #(
  parameter int TIME       = 50_000_000,
  parameter int TIMEOUT    = 2_000_000,
  parameter int TRIG_CLKS  = 500,
  parameter int BIT_CLKS   = 434,
  parameter int CM_CLKS    = 2941,
  parameter int PWM_PERIOD = 1_000_000,
  parameter int PWM_BASE   = 50_000,
  parameter int PWM_STEP   = 7_143
) (
  input  logic clock,
  input  logic reset,
  input  logic ligar,
  input  logic echo,
  output logic trigger,
  output logic pwm,
  output logic saida_serial,
  output logic fim_posicao
);

  localparam int HALF_CM = CM_CLKS / 2;

  typedef enum logic [2:0] {
    INICIAL, ESPERA, TRIGGER, MEDE, TRANSMITE, FIM, PROXIMA
  } state_t;

  state_t      state, next_state;
  logic [31:0] cnt, cyc, pwm_cnt, duty, duty_next;
  logic [2:0]  pos_idx, byte_idx;
  logic        dir_up;
  logic [3:0]  bit_idx;
  logic [3:0]  dist2, dist1, dist0, inc2, inc1, inc0;
  logic [3:0]  ang2, ang1;
  logic        echo_m, echo_s, echo_d, measuring;
  logic        rise, cm_inc, meas_timeout, meas_done, bit_end, tx_last;
  logic [7:0]  tx_byte;
  logic [9:0]  tx_frame;

  // Two flops bring echo into the clock domain; the third detects the rise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  assign rise         = echo_s & ~echo_d;
  assign cm_inc       = (state == MEDE) && ((!measuring && rise) || (measuring && echo_s));
  assign meas_timeout = (state == MEDE) &&
                        ((!measuring && !rise && cnt == TIMEOUT - 1) ||
                         (measuring && echo_s && cnt == TIMEOUT));
  assign meas_done    = meas_timeout || (state == MEDE && measuring && !echo_s);
  assign bit_end      = (cnt == BIT_CLKS - 1);
  assign tx_last      = bit_end && (bit_idx == 4'd9) && (byte_idx == 3'd7);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= INICIAL;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    trigger      = 1'b0;
    saida_serial = 1'b1;
    fim_posicao  = 1'b0;
    case (state)
      INICIAL:   if (ligar) next_state = ESPERA;
      ESPERA:    if (cnt == TIME - 1) next_state = TRIGGER;
      TRIGGER: begin
        trigger = 1'b1;
        if (cnt == TRIG_CLKS - 1) next_state = MEDE;
      end
      MEDE:      if (meas_done) next_state = TRANSMITE;
      TRANSMITE: begin
        saida_serial = tx_frame[bit_idx];
        if (tx_last) next_state = FIM;
      end
      FIM: begin
        fim_posicao = 1'b1;
        next_state  = PROXIMA;
      end
      PROXIMA:   next_state = ESPERA;
      default:   next_state = INICIAL;
    endcase
    if (state != INICIAL && !ligar) next_state = INICIAL;
  end

  // Saturating 3-digit BCD increment of the distance.
  always_comb begin
    inc2 = dist2;
    inc1 = dist1;
    inc0 = dist0;
    if (!(dist2 == 4'd9 && dist1 == 4'd9 && dist0 == 4'd9)) begin
      if (dist0 != 4'd9) begin
        inc0 = dist0 + 4'd1;
      end else begin
        inc0 = 4'd0;
        if (dist1 != 4'd9) begin
          inc1 = dist1 + 4'd1;
        end else begin
          inc1 = 4'd0;
          inc2 = dist2 + 4'd1;
        end
      end
    end
  end

  always_comb begin
    ang2 = 4'd0;
    ang1 = 4'd0;
    case (pos_idx)
      3'd0: ang1 = 4'd2;
      3'd1: ang1 = 4'd4;
      3'd2: ang1 = 4'd6;
      3'd3: ang1 = 4'd8;
      3'd4: begin ang2 = 4'd1; ang1 = 4'd0; end
      3'd5: begin ang2 = 4'd1; ang1 = 4'd2; end
      3'd6: begin ang2 = 4'd1; ang1 = 4'd4; end
      default: begin ang2 = 4'd1; ang1 = 4'd6; end
    endcase
  end

  always_comb begin
    tx_byte = 8'h23;
    case (byte_idx)
      3'd0: tx_byte = {4'h3, ang2};
      3'd1: tx_byte = {4'h3, ang1};
      3'd2: tx_byte = 8'h30;
      3'd3: tx_byte = 8'h2C;
      3'd4: tx_byte = {4'h3, dist2};
      3'd5: tx_byte = {4'h3, dist1};
      3'd6: tx_byte = {4'h3, dist0};
      default: tx_byte = 8'h23;
    endcase
  end

  assign tx_frame = {1'b1, tx_byte, 1'b0};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= 32'd0;
      cyc       <= 32'd0;
      measuring <= 1'b0;
      dist2     <= 4'd0;
      dist1     <= 4'd0;
      dist0     <= 4'd0;
      bit_idx   <= 4'd0;
      byte_idx  <= 3'd0;
      pos_idx   <= 3'd0;
      dir_up    <= 1'b1;
    end else begin
      cnt <= cnt + 32'd1;
      case (state)
        TRIGGER: begin
          measuring <= 1'b0;
          cyc       <= HALF_CM;
          dist2     <= 4'd0;
          dist1     <= 4'd0;
          dist0     <= 4'd0;
        end
        MEDE: begin
          if (!measuring && rise) begin
            measuring <= 1'b1;
            cnt       <= 32'd1;
          end
          // cyc starts half a centimetre in, so each wrap rounds to nearest cm.
          if (cm_inc) begin
            if (cyc == CM_CLKS - 1) begin
              cyc   <= 32'd0;
              dist2 <= inc2;
              dist1 <= inc1;
              dist0 <= inc0;
            end else begin
              cyc <= cyc + 32'd1;
            end
          end
          if (meas_timeout) begin
            dist2 <= 4'd9;
            dist1 <= 4'd9;
            dist0 <= 4'd9;
          end
        end
        TRANSMITE: begin
          if (bit_end) begin
            cnt <= 32'd0;
            if (bit_idx == 4'd9) begin
              bit_idx  <= 4'd0;
              byte_idx <= byte_idx + 3'd1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        PROXIMA: begin
          if (dir_up) begin
            if (pos_idx == 3'd7) begin
              pos_idx <= 3'd6;
              dir_up  <= 1'b0;
            end else begin
              pos_idx <= pos_idx + 3'd1;
            end
          end else begin
            if (pos_idx == 3'd0) begin
              pos_idx <= 3'd1;
              dir_up  <= 1'b1;
            end else begin
              pos_idx <= pos_idx - 3'd1;
            end
          end
        end
        default: ;
      endcase
      if (state != TRANSMITE) begin
        bit_idx  <= 4'd0;
        byte_idx <= 3'd0;
      end
      if (next_state != state) cnt <= 32'd0;
    end
  end

  // Duty is only reloaded at the period boundary so no pulse is ever truncated.
  assign duty_next = PWM_BASE + PWM_STEP * {29'd0, pos_idx};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= 32'd0;
      duty    <= PWM_BASE;
    end else if (pwm_cnt == PWM_PERIOD - 1) begin
      pwm_cnt <= 32'd0;
      duty    <= duty_next;
    end else begin
      pwm_cnt <= pwm_cnt + 32'd1;
    end
  end

  assign pwm = (pwm_cnt < duty);

endmodule

// File: tb/tb_exp5_sonar.sv
// tb/tb_exp5_sonar.sv - self-checking bench for exp5_sonar with a UART receiver and ranging model
module tb_exp5_sonar;

  localparam int TIME       = 500;
  localparam int TIMEOUT    = 8000;
  localparam int TRIG_CLKS  = 20;
  localparam int BIT_CLKS   = 8;
  localparam int CM_CLKS    = 7;
  localparam int PWM_PERIOD = 200;
  localparam int PWM_BASE   = 40;
  localparam int PWM_STEP   = 15;

  logic clock = 1'b0;
  logic reset, ligar, echo;
  logic trigger, pwm, saida_serial, fim_posicao;

  exp5_sonar #(
    .TIME(TIME), .TIMEOUT(TIMEOUT), .TRIG_CLKS(TRIG_CLKS), .BIT_CLKS(BIT_CLKS),
    .CM_CLKS(CM_CLKS), .PWM_PERIOD(PWM_PERIOD), .PWM_BASE(PWM_BASE), .PWM_STEP(PWM_STEP)
  ) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .echo(echo),
    .trigger(trigger), .pwm(pwm), .saida_serial(saida_serial), .fim_posicao(fim_posicao)
  );

  always #10 clock = ~clock;

  typedef struct {
    int w;
    int cm;
  } vec_t;

  vec_t vecs[9];
  int   passed = 0;
  int   total  = 0;
  int   step_n = 0;
  int   exp_b[8];

  int   fim_count = 0;
  int   last_high = 0, last_period = 0, hi_run = 0, since_rise = 0;
  logic pwm_q = 1'b0;

  always @(negedge clock) begin
    if (fim_posicao) fim_count <= fim_count + 1;
    if (pwm && !pwm_q) begin
      last_period <= since_rise;
      since_rise  <= 1;
      hi_run      <= 1;
    end else begin
      since_rise <= since_rise + 1;
      if (pwm) hi_run <= hi_run + 1;
    end
    if (!pwm && pwm_q) last_high <= hi_run;
    pwm_q <= pwm;
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic int exp_idx(input int s);
    int m;
    m = s % 14;
    return (m < 8) ? m : 14 - m;
  endfunction

  function automatic int exp_cm(input int w);
    int v;
    v = (w + CM_CLKS / 2) / CM_CLKS;
    return (v > 999) ? 999 : v;
  endfunction

  task automatic build_exp(input int idx, input int d);
    int a;
    a = 20 * (idx + 1);
    exp_b[0] = 48 + a / 100;
    exp_b[1] = 48 + (a / 10) % 10;
    exp_b[2] = 48 + a % 10;
    exp_b[3] = 44;
    exp_b[4] = 48 + d / 100;
    exp_b[5] = 48 + (d / 10) % 10;
    exp_b[6] = 48 + d % 10;
    exp_b[7] = 35;
  endtask

  task automatic rx_byte(output int b, output bit ok);
    int d;
    d  = 0;
    b  = 0;
    ok = 1'b0;
    while (saida_serial && d < TIMEOUT + 500) begin @(negedge clock); d++; end
    if (saida_serial) return;
    repeat (BIT_CLKS / 2) @(negedge clock);
    if (saida_serial) return;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_CLKS) @(negedge clock);
      if (saida_serial) b = b | (1 << i);
    end
    repeat (BIT_CLKS) @(negedge clock);
    ok = saida_serial;
  endtask

  task automatic wait_trigger(input int level, output bit ok, output int d);
    d = 0;
    while (int'(trigger) != level && d < TIME + TIMEOUT) begin @(negedge clock); d++; end
    ok = (int'(trigger) == level);
  endtask

  // One full position: trigger timing, pwm duty, echo stimulus, frame decode, fim pulse.
  task automatic run_position(input int w, input int exp_d, input bit chk_delay);
    int  d, b, f0, eh;
    bit  ok;
    build_exp(exp_idx(step_n), exp_d);
    eh = PWM_BASE + exp_idx(step_n) * PWM_STEP;
    wait_trigger(1, ok, d);
    check("trig_start", int'(ok), 1);
    if (!ok) return;
    if (chk_delay) check_range("trig_delay", d, TIME, TIME + 2);
    check_range("pwm_high", last_high, eh - 1, eh + 1);
    check("pwm_period", last_period, PWM_PERIOD);
    wait_trigger(0, ok, d);
    check("trig_width", d, TRIG_CLKS);
    repeat (5) @(negedge clock);
    if (w > 0) begin
      echo = 1'b1;
      repeat (w) @(negedge clock);
      echo = 1'b0;
    end
    f0 = fim_count;
    for (int k = 0; k < 8; k++) begin
      rx_byte(b, ok);
      check($sformatf("byte%0d_step%0d", k, step_n), ok ? b : -1, exp_b[k]);
      if (!ok) return;
    end
    d = 0;
    while (!fim_posicao && d < 2 * BIT_CLKS) begin @(negedge clock); d++; end
    check("fim_pulse", int'(fim_posicao), 1);
    @(negedge clock);
    check("fim_width", int'(fim_posicao), 0);
    check("fim_count", fim_count - f0, 1);
    step_n++;
  endtask

  initial begin
    #(20 * 100_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int  d, b, f0, w;
    bit  ok, stayed;

    vecs[0] = '{697, 100};
    vecs[1] = '{699, 100};
    vecs[2] = '{521, 74};
    vecs[3] = '{522, 75};
    vecs[4] = '{3, 0};
    vecs[5] = '{4, 1};
    vecs[6] = '{703, 100};
    vecs[7] = '{704, 101};
    vecs[8] = '{7500, 999};

    reset = 1'b0;
    ligar = 1'b0;
    echo  = 1'b0;
    repeat (100) @(negedge clock);
    check("rst_trigger", int'(trigger), 0);
    check("rst_serial", int'(saida_serial), 1);
    check("rst_fim", int'(fim_posicao), 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_trigger", int'(trigger), 0);
    ligar = 1'b1;

    for (int i = 0; i < 9; i++) begin
      check($sformatf("model_cm_vec%0d", i), exp_cm(vecs[i].w), vecs[i].cm);
      run_position(vecs[i].w, vecs[i].cm, i == 0);
    end

    for (int i = 0; i < 5; i++) begin
      w = $urandom_range(1, 1500);
      run_position(w, exp_cm(w), 1'b0);
    end

    run_position(0, 999, 1'b0);

    // Abort mid-frame: line idles next clock, no fim, index kept.
    wait_trigger(1, ok, d);
    wait_trigger(0, ok, d);
    repeat (5) @(negedge clock);
    echo = 1'b1;
    repeat (100) @(negedge clock);
    echo = 1'b0;
    build_exp(exp_idx(step_n), exp_cm(100));
    for (int k = 0; k < 2; k++) begin
      rx_byte(b, ok);
      check($sformatf("abort_byte%0d", k), ok ? b : -1, exp_b[k]);
    end
    d = 0;
    while (saida_serial && d < 4 * BIT_CLKS) begin @(negedge clock); d++; end
    check("abort_start_bit", int'(saida_serial), 0);
    repeat (2) @(negedge clock);
    f0    = fim_count;
    ligar = 1'b0;
    @(negedge clock);
    check("abort_serial", int'(saida_serial), 1);
    check("abort_trigger", int'(trigger), 0);
    stayed = 1'b1;
    repeat (3 * BIT_CLKS) begin
      @(negedge clock);
      if (!saida_serial) stayed = 1'b0;
    end
    check("abort_idle", int'(stayed), 1);
    check("abort_no_fim", fim_count - f0, 0);
    ligar = 1'b1;
    run_position(50, exp_cm(50), 1'b1);

    // Asynchronous reset in the middle of a measurement.
    wait_trigger(1, ok, d);
    wait_trigger(0, ok, d);
    repeat (3) @(negedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_trigger", int'(trigger), 0);
    check("mid_rst_serial", int'(saida_serial), 1);
    check("mid_rst_fim", int'(fim_posicao), 0);
    repeat (3) @(negedge clock);
    reset  = 1'b1;
    step_n = 0;
    run_position(200, exp_cm(200), 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
